// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with a valid/ready output register.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit
// between the data bits and the stop bit (frame becomes 11 bits).
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  data_out,
    output logic        valid,
    input  logic        ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        led_rx,
    output logic [15:0] byte_count
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state, state_nxt;
    logic        rx_meta, rx_sync;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_done, half_done;
    logic        stop_sample, good_frame, bad_frame;
`ifdef UART_RX_PARITY_EN
    logic        par_err;
`endif

    assign bit_done  = (cnt == BIT_LAST);
    assign half_done = (cnt == HALF_LAST);

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; every decision uses the synchronized line
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_sync) state_nxt = START;
            START:     if (half_done) state_nxt = rx_sync ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:      if (bit_done && bit_idx == 3'd7) state_nxt = PARITY;
            PARITY:    if (bit_done) state_nxt = STOP;
`else
            DATA:      if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
`endif
            STOP:      if (bit_done) state_nxt = rx_sync ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_sync) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output decode: busy indicator and stop-bit verdict
    always_comb begin
        led_rx      = (state != IDLE);
        stop_sample = (state == STOP) && bit_done;
`ifdef UART_RX_PARITY_EN
        good_frame  = stop_sample && rx_sync && !par_err;
`else
        good_frame  = stop_sample && rx_sync;
`endif
        bad_frame   = stop_sample && !good_frame;
    end

    // Bit-period counter: cleared on every state change and after each data
    // sample; free of any edge resynchronization
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst)                                   cnt <= '0;
        else if (state_nxt != state)               cnt <= '0;
        else if (state == DATA && bit_done)        cnt <= '0;
        else if (state == IDLE || state == WAIT_IDLE) cnt <= '0;
        else                                       cnt <= cnt + 16'd1;
    end

    // Data shift register, LSB first, plus parity check
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            if (state == DATA) begin
                if (bit_done) begin
                    shreg   <= {rx_sync, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                bit_idx <= '0;
            end
`ifdef UART_RX_PARITY_EN
            // Even parity: the parity bit must equal the XOR of the data bits
            if (state == PARITY && bit_done) par_err <= (rx_sync != ^shreg);
`endif
        end
    end

    // Output register with valid/ready handshake, error and overrun pulses
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            byte_count <= '0;
        end else begin
            frame_err <= bad_frame;
            overrun   <= good_frame && valid && !ready;
            if (good_frame && (!valid || ready)) begin
                data_out   <= shreg;
                valid      <= 1'b1;
                byte_count <= byte_count + 16'd1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: directed frames plus randomized traffic, checked
// every cycle against a frame-level model (frame verdict lands a fixed number
// of cycles after the start bit is driven, then the handshake rules apply).
module tb_uart_rx_byte;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Cycles from the first clock edge that sees the start bit to the edge
    // on which the stop-bit verdict is registered.
    localparam int LAT = 2 + H + (NB - 1) * CPB;

    logic        clk_100, rst, rx, ready;
    logic [7:0]  data_out;
    logic        valid, frame_err, overrun, led_rx;
    logic [15:0] byte_count;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk_100(clk_100), .rst(rst), .rx(rx), .data_out(data_out),
        .valid(valid), .ready(ready), .frame_err(frame_err),
        .overrun(overrun), .led_rx(led_rx), .byte_count(byte_count)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    typedef struct {
        int         c;
        logic [7:0] d;
        bit         good;
    } ev_t;

    ev_t  evq[$];
    ev_t  e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   fe_seen = 0;
    int   ov_seen = 0;
    bit   rdy_rand = 0;

    logic        vm;
    logic [7:0]  dm;
    logic [15:0] cm;
    logic        fem, ovm;
    bit          load;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Model + per-cycle compare, just after each rising edge
    always begin
        @(posedge clk_100);
        cyc++;
        #1;
        fem = 1'b0;
        ovm = 1'b0;
        if (rst) begin
            vm = 1'b0; dm = 8'h00; cm = 16'h0000;
            evq.delete();
        end else begin
            load = 0;
            if (evq.size() > 0 && evq[0].c == cyc) begin
                e = evq.pop_front();
                if (e.good) begin
                    if (!vm || ready) begin
                        dm = e.d; vm = 1'b1; cm = cm + 16'd1; load = 1;
                    end else begin
                        ovm = 1'b1;
                    end
                end else begin
                    fem = 1'b1;
                end
            end
            if (!load && vm && ready) vm = 1'b0;
        end
        chk("valid", 16'(valid), 16'(vm));
        chk("data_out", 16'(data_out), 16'(dm));
        chk("frame_err", 16'(frame_err), 16'(fem));
        chk("overrun", 16'(overrun), 16'(ovm));
        chk("byte_count", byte_count, cm);
        if (frame_err) fe_seen++;
        if (overrun) ov_seen++;
    end

    task automatic tick();
        @(negedge clk_100);
        if (rdy_rand) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic reset_dut();
        rst = 1'b1; rx = 1'b1; ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    // Drive one frame starting at the current falling edge. abort_at >= 0
    // stops halfway through that frame bit (no verdict is expected).
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic par_flip, input int abort_at);
        logic [10:0] bits;
        ev_t ev;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9] = (^d) ^ par_flip;
        ev.good = stop_b && !par_flip;
`else
        ev.good = stop_b;
`endif
        bits[NB-1] = stop_b;
        ev.c = cyc + 1 + LAT;
        ev.d = d;
        if (abort_at < 0) evq.push_back(ev);
        for (int j = 0; j < NB; j++) begin
            rx = bits[j];
            if (j == abort_at) begin
                repeat (H) tick();
                return;
            end
            repeat (CPB) tick();
        end
    endtask

    int fe0, ov0, gap;
    logic [7:0] rd;
    bit rbad, rpf;

    initial begin
        rst = 1'b1; rx = 1'b1; ready = 1'b0;
        repeat (3) tick();
        // Reset state
        chk("rst_valid", 16'(valid), 16'h0);
        chk("rst_data", 16'(data_out), 16'h00);
        chk("rst_count", byte_count, 16'h0);
        chk("rst_led", 16'(led_rx), 16'h0);
        rst = 1'b0;
        repeat (2) tick();

        // Single good frame, then one ready cycle clears valid
        reset_dut();
        send_frame(8'h0F, 1'b1, 1'b0, -1);
        idle(2);
        chk("single_valid", 16'(valid), 16'h1);
        chk("single_data", 16'(data_out), 16'h0F);
        chk("single_count", byte_count, 16'h1);
        chk("model_count", cm, 16'h1);
        ready = 1'b1;
        tick();
        chk("ready_clears", 16'(valid), 16'h0);
        ready = 1'b0;

        // Back-to-back with ready low: second byte is an overrun
        reset_dut();
        ov0 = ov_seen;
        send_frame(8'h0F, 1'b1, 1'b0, -1);
        send_frame(8'hF0, 1'b1, 1'b0, -1);
        idle(CPB);
        chk("ovr_data", 16'(data_out), 16'h0F);
        chk("ovr_count", byte_count, 16'h1);
        chk("ovr_pulses", 16'(ov_seen - ov0), 16'h1);
        chk("ovr_valid", 16'(valid), 16'h1);

        // Bad stop bit, then recovery on the next frame
        reset_dut();
        fe0 = fe_seen;
        send_frame(8'hF0, 1'b0, 1'b0, -1);
        idle(2 * CPB);
        chk("ferr_pulses", 16'(fe_seen - fe0), 16'h1);
        chk("ferr_novalid", 16'(valid), 16'h0);
        send_frame(8'h98, 1'b1, 1'b0, -1);
        idle(2);
        chk("after_ferr_data", 16'(data_out), 16'h98);
        chk("after_ferr_count", byte_count, 16'h1);

        // Break: line held low well past the frame gives one frame_err
        ready = 1'b1;
        fe0 = fe_seen;
        send_frame(8'h00, 1'b0, 1'b0, -1);
        repeat (4 * CPB) tick();
        idle(2 * CPB);
        chk("break_pulses", 16'(fe_seen - fe0), 16'h1);
        ready = 1'b0;

        // Short glitch is rejected silently
        reset_dut();
        fe0 = fe_seen;
        rx = 1'b0;
        repeat (4) tick();
        chk("glitch_led", 16'(led_rx), 16'h1);
        tick();
        idle(2 * CPB);
        chk("glitch_led_off", 16'(led_rx), 16'h0);
        chk("glitch_novalid", 16'(valid), 16'h0);
        chk("glitch_noferr", 16'(fe_seen - fe0), 16'h0);

        // Reset during data bit 4 clears everything; next frame is clean
        reset_dut();
        send_frame(8'h55, 1'b1, 1'b0, -1);
        send_frame(8'h31, 1'b1, 1'b0, 5);
        rst = 1'b1; rx = 1'b1;
        repeat (2) tick();
        chk("midrst_valid", 16'(valid), 16'h0);
        chk("midrst_data", 16'(data_out), 16'h00);
        chk("midrst_count", byte_count, 16'h0);
        chk("midrst_led", 16'(led_rx), 16'h0);
        rst = 1'b0;
        idle(CPB);
        send_frame(8'h31, 1'b1, 1'b0, -1);
        idle(2);
        chk("midrst_next_data", 16'(data_out), 16'h31);
        chk("midrst_next_count", byte_count, 16'h1);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x0F needs parity 0
        reset_dut();
        fe0 = fe_seen;
        send_frame(8'h0F, 1'b1, 1'b1, -1);
        idle(2);
        chk("par_bad_ferr", 16'(fe_seen - fe0), 16'h1);
        chk("par_bad_novalid", 16'(valid), 16'h0);
        send_frame(8'h0F, 1'b1, 1'b0, -1);
        idle(2);
        chk("par_ok_valid", 16'(valid), 16'h1);
        chk("par_ok_data", 16'(data_out), 16'h0F);
`endif

        // Randomized traffic with random ready and occasional bad frames
        reset_dut();
        rdy_rand = 1;
        for (int i = 0; i < 150; i++) begin
            rd   = 8'($urandom);
            rbad = ($urandom_range(0, 7) == 0);
`ifdef UART_RX_PARITY_EN
            rpf  = ($urandom_range(0, 7) == 0);
`else
            rpf  = 1'b0;
`endif
            send_frame(rd, !rbad, rpf, -1);
            gap = rbad ? CPB + int'($urandom_range(0, CPB)) : int'($urandom_range(0, 2 * CPB));
            idle(gap);
        end
        idle(2 * CPB);
        rdy_rand = 0;
        chk("queue_drained", 16'(evq.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
